// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller.
// Start detect, 9x sample voting, frame assembly and error flags.
module uart_rx_ctrl #(
   parameter int DATA_BITS  = 8,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 sample_clk,
   output logic                 rx_start,
   output logic                 rx_done,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic                 rx_s1;
   logic                 rx_s2;
   logic                 rx_prev;
   logic [2:0]           state;
   logic [3:0]           tick;
   logic [1:0]           votes;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] sh;
   logic                 par_bad;

   logic                 fall;
   logic                 in_win;
   logic [1:0]           votes_nx;
   logic                 bit_val;
   logic                 last_bit;
   logic                 at_mid;
   logic                 at_end;

   // Edge detect, vote accumulation including the current sample
   always_comb begin
      fall     = rx_prev & ~rx_s2;
      in_win   = (tick >= 4'd3) && (tick <= 4'd5);
      votes_nx = votes + {1'b0, in_win & rx_s2};
      bit_val  = votes_nx[1];
      last_bit = (bit_cnt == 4'(DATA_BITS - 1));
      at_mid   = (tick == 4'd5);
      at_end   = (tick == 4'd8);
   end

   // Two-flop synchronizer plus previous-value flop, idle high
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Frame FSM: ticks and votes advance only on sample pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         tick       <= 4'd0;
         votes      <= 2'd0;
         bit_cnt    <= 4'd0;
         sh         <= '0;
         par_bad    <= 1'b0;
         rx_start   <= 1'b0;
         rx_done    <= 1'b0;
         data_valid <= 1'b0;
         data       <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_start   <= 1'b0;
         rx_done    <= 1'b0;
         data_valid <= 1'b0;
         if (state == S_IDLE) begin
            if (fall) begin
               rx_start <= 1'b1;
               state    <= S_START;
               tick     <= 4'd0;
               votes    <= 2'd0;
            end
         end else if (sample_clk) begin
            if (at_end) begin
               tick  <= 4'd0;
               votes <= 2'd0;
            end else begin
               tick  <= tick + 4'd1;
               votes <= votes_nx;
            end
            unique case (state)
               S_START: begin
                  if (at_mid && bit_val) begin
                     rx_done <= 1'b1;
                     state   <= S_IDLE;
                     tick    <= 4'd0;
                     votes   <= 2'd0;
                  end else if (at_end) begin
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (at_mid) begin
                     sh <= {bit_val, sh[DATA_BITS-1:1]};
                  end
                  if (at_end) begin
                     if (last_bit) begin
                        bit_cnt <= 4'd0;
                        state   <= PARITY_EN ? S_PARITY : S_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               S_PARITY: begin
                  if (at_mid) begin
                     par_bad <= bit_val ^ (^sh) ^ PARITY_ODD;
                  end
                  if (at_end) begin
                     state <= S_STOP;
                  end
               end
               S_STOP: begin
                  if (at_mid) begin
                     rx_done    <= 1'b1;
                     data_valid <= 1'b1;
                     data       <= sh;
                     frame_err  <= ~bit_val;
                     parity_err <= PARITY_EN & par_bad;
                     state      <= S_IDLE;
                     tick       <= 4'd0;
                     votes      <= 2'd0;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl.
// Instance 0 is 8N1, instance 1 is 8E1; a bench model plays the sample-clock generator.
module tb_uart_rx_ctrl;

   localparam int P  = 4;
   localparam int BT = 9 * P;

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       f;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] rx_l = 2'b11;
   logic [1:0] sc = 2'b00;
   logic [1:0] rs;
   logic [1:0] rd;
   logic [1:0] dv;
   logic [1:0] pe;
   logic [1:0] fe;
   logic [7:0] dt0;
   logic [7:0] dt1;

   exp_t fq0[$];
   exp_t fq1[$];
   int   sq0[$];
   int   sq1[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int exp_st[2] = '{0, 0};
   int exp_dn[2] = '{0, 0};
   int cnt_st[2] = '{0, 0};
   int cnt_dn[2] = '{0, 0};
   int kill[2]   = '{0, 0};

   uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_n (
      .clk(clk), .rst(rst), .rx(rx_l[0]), .sample_clk(sc[0]),
      .rx_start(rs[0]), .rx_done(rd[0]), .data(dt0),
      .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0])
   );

   uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_p (
      .clk(clk), .rst(rst), .rx(rx_l[1]), .sample_clk(sc[1]),
      .rx_start(rs[1]), .rx_done(rd[1]), .data(dt1),
      .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic pop_s(input int i, output bit ok, output int e);
      ok = 0;
      e  = 0;
      if (i == 0) begin
         if (sq0.size() > 0) begin ok = 1; e = sq0.pop_front(); end
      end else begin
         if (sq1.size() > 0) begin ok = 1; e = sq1.pop_front(); end
      end
   endtask

   task automatic pop_f(input int i, output bit ok, output exp_t e);
      ok = 0;
      e  = '{8'h00, 1'b0, 1'b0};
      if (i == 0) begin
         if (fq0.size() > 0) begin ok = 1; e = fq0.pop_front(); end
      end else begin
         if (fq1.size() > 0) begin ok = 1; e = fq1.pop_front(); end
      end
   endtask

   task automatic push_s(input int i, input int e);
      if (i == 0) sq0.push_back(e);
      else sq1.push_back(e);
   endtask

   // Sample-clock generator model: pulse every P clocks between start and done
   initial begin
      bit act[2];
      int cnt[2];
      int seen[2];
      act  = '{0, 0};
      cnt  = '{0, 0};
      seen = '{0, 0};
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (kill[i] != seen[i]) begin
               seen[i] = kill[i];
               act[i]  = 0;
               sc[i]   = 1'b0;
            end else if (rd[i]) begin
               act[i] = 0;
               sc[i]  = 1'b0;
            end else if (rs[i]) begin
               act[i] = 1;
               cnt[i] = 0;
               sc[i]  = 1'b0;
            end else if (act[i]) begin
               cnt[i]++;
               if (cnt[i] == P) begin
                  cnt[i] = 0;
                  sc[i]  = 1'b1;
               end else begin
                  sc[i] = 1'b0;
               end
            end else begin
               sc[i] = 1'b0;
            end
         end
      end
   end

   // Monitor: pops expectations whenever a DUT presents a pulse
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            bit         ok;
            int         es;
            exp_t       ef;
            logic [7:0] d;
            d = (i == 0) ? dt0 : dt1;
            if (rs[i] || rd[i]) check("start_done_excl", 32'(rs[i] & rd[i]), 0);
            if (rs[i]) begin
               cnt_st[i]++;
               pop_s(i, ok, es);
               if (!ok) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_rx_start inst=%0d cyc=%0d", i, cyc);
               end else begin
                  check("rx_start_latency", cyc, es);
               end
            end
            if (rd[i]) cnt_dn[i]++;
            if (dv[i]) begin
               check("done_with_valid", 32'(rd[i]), 1);
               pop_f(i, ok, ef);
               if (!ok) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_valid inst=%0d data=%0h", i, d);
               end else begin
                  check("data", 32'(d), 32'(ef.d));
                  check("parity_err", 32'(pe[i]), 32'(ef.p));
                  check("frame_err", 32'(fe[i]), 32'(ef.f));
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_l = 2'b11;
      end
   endtask

   // Drive one frame; gl inverts the tick-4 sample of that frame bit,
   // rst_at >= 0 aborts the frame with a one-cycle reset at that cycle
   task automatic send(input int i, input logic [7:0] b, input bit pflip,
                       input bit stop_v, input int gl, input int rst_at);
      logic bits[$];
      exp_t e;
      bit   pen;
      pen = (i == 1);
      bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) bits.push_back(b[k]);
      if (pen) bits.push_back((^b) ^ pflip);
      bits.push_back(stop_v);
      e.d = b;
      e.p = pen & pflip;
      e.f = !stop_v;
      exp_st[i]++;
      if (rst_at < 0) begin
         exp_dn[i]++;
         if (i == 0) fq0.push_back(e);
         else fq1.push_back(e);
      end
      for (int k = 0; k < bits.size(); k++) begin
         for (int c = 0; c < BT; c++) begin
            @(negedge clk);
            if (k * BT + c == rst_at) begin
               rst     = 1'b1;
               rx_l[i] = 1'b1;
               kill[i]++;
               @(negedge clk);
               rst = 1'b0;
               return;
            end
            rx_l[i] = bits[k] ^ ((k == gl) && (c == 1 + 5 * P));
            if (k == 0 && c == 0) push_s(i, cyc + 3);
         end
      end
   endtask

   // Start bit that returns high after two sample periods
   task automatic false_start(input int i);
      exp_st[i]++;
      exp_dn[i]++;
      for (int c = 0; c < BT; c++) begin
         @(negedge clk);
         rx_l[i] = (c >= 2 * P);
         if (c == 0) push_s(i, cyc + 3);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_data0", 32'(dt0), 0);
      check("rst_data1", 32'(dt1), 0);
      check("rst_rx_start", 32'(rs), 0);
      check("rst_rx_done", 32'(rd), 0);
      check("rst_data_valid", 32'(dv), 0);
      check("rst_parity_err", 32'(pe), 0);
      check("rst_frame_err", 32'(fe), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int         i;
      int         gl;
      int         gap;
      logic [7:0] b;
      bit         pf;
      bit         sv;
      rst  = 1'b1;
      rx_l = 2'b11;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      idle(10);

      send(0, 8'h55, 0, 1, -1, -1);
      idle(20);
      send(1, 8'hA3, 1, 1, -1, -1);
      idle(20);
      false_start(0);
      idle(BT);
      send(0, 8'h3C, 0, 1, -1, -1);
      idle(20);
      send(0, 8'hF0, 0, 0, -1, -1);
      idle(20);
      send(0, 8'h00, 0, 1, -1, -1);
      send(0, 8'hFF, 0, 1, 3, -1);
      idle(20);
      send(0, 8'h5A, 0, 1, -1, 5 * BT + 10);
      check_reset_outputs();
      idle(20);
      send(0, 8'h81, 0, 1, -1, -1);
      idle(20);

      repeat (30) begin
         i   = int'($urandom_range(0, 1));
         b   = 8'($urandom);
         pf  = 1'($urandom);
         sv  = ($urandom_range(0, 3) != 0);
         gl  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
         send(i, b, pf, sv, gl, -1);
         gap = sv ? int'($urandom_range(0, 2)) * 7 : int'($urandom_range(4, 14));
         if (gap > 0) idle(gap);
      end
      idle(3 * BT);

      for (int k = 0; k < 2; k++) begin
         check("rx_start_count", cnt_st[k], exp_st[k]);
         check("rx_done_count", cnt_dn[k], exp_dn[k]);
      end
      check("frames_left0", fq0.size(), 0);
      check("frames_left1", fq1.size(), 0);
      check("starts_left0", sq0.size(), 0);
      check("starts_left1", sq1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame controller for the UART receive path. It detects the start edge on the serial line and issues `rx_start` to the 9×-baud sample-clock generator. It then counts the `sample_clk` pulses that come back, majority-votes each bit, and assembles start, data, optional parity and stop bits. At the end of the frame it pulses `rx_done` to stop the generator and presents the byte with its error flags to the downstream consumer.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first on the line.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: with `PARITY_EN`=1, 1 selects odd parity, 0 selects even.
- `clk` in 1: system clock; one clock for the whole block.
- `rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial input, idle high.
- `sample_clk` in 1: one-`clk` pulse at 9× baud from the sample-clock generator.
- `rx_start` out 1: one-cycle pulse that starts the sample-clock generator.
- `rx_done` out 1: one-cycle pulse that stops the sample-clock generator.
- `data` out DATA_BITS: last received word; holds until the next `data_valid`.
- `data_valid` out 1: one-cycle pulse when a frame completes; `data` and flags are valid in this cycle.
- `parity_err` out 1: parity mismatch of the last frame; 0 when `PARITY_EN`=0; updated with `data_valid`.
- `frame_err` out 1: stop bit voted 0 in the last frame; updated with `data_valid`.

## Operation
- Input sync: `rx` passes through two flops (`rx_s1`, `rx_s2`) plus a previous-value flop `rx_prev`. All three reset to 1.
- Falling edge: `rx_prev`=1 and `rx_s2`=0.
- States: IDLE, START, DATA, PARITY, STOP.
- Tick counter `tick` (0..8) counts `sample_clk` pulses within the current bit.
  - Cleared on entry to every state.
  - Wraps 8→0 and moves to the next bit.
- Vote register `votes` (2 bits) counts `rx_s2`=1 on the pulses where `tick` is 3, 4 or 5.
  - Bit value = `votes` ≥ 2.
  - The vote is evaluated on the `sample_clk` pulse where `tick`=5.
- IDLE: on a falling edge, pulse `rx_start`, go to START. `sample_clk` is ignored in IDLE.
- START:
  - The vote is evaluated at `tick`=5.
  - If it is 1 (false start): pulse `rx_done`, return to IDLE, no `data_valid`.
  - Otherwise continue to `tick`=8, then go to DATA.
- DATA:
  - At `tick`=5, shift the voted bit into the MSB of shift register `sh` (right shift), so the first received bit ends in bit 0.
  - Bit index `bit_cnt` counts 0..DATA_BITS-1.
  - After the last bit's `tick`=8, go to PARITY if `PARITY_EN`, else STOP.
- PARITY: at `tick`=5, store `par_bad` = voted bit XOR (^`sh`) XOR `PARITY_ODD`. Go to STOP after `tick`=8.
- STOP:
  - At `tick`=5 (mid stop bit), on the same cycle: pulse `rx_done` and `data_valid`, load `data`←`sh`, set `frame_err`←(voted bit==0), set `parity_err`←`par_bad`, go to IDLE.
  - Ending at mid stop bit gives drift margin and lets a back-to-back start edge be caught.
- After an error the frame is still delivered, with its flag set.
- Reset mid-frame: everything returns to reset values. No `rx_done` is issued; `rst` resets the generator too.

## Timing
- Reset values:
  - outputs: `rx_start`, `rx_done`, `data_valid`, `parity_err`, `frame_err` = 0, `data` = 0;
  - internals: state IDLE, `tick`=0, `votes`=0, `bit_cnt`=0, `sh`=0, `par_bad`=0.
- All outputs are registered.
- `rx` falling edge → `rx_start` 3 `clk` cycles later (2 sync flops plus 1 output register).
- `data_valid` and `rx_done` assert 1 `clk` after the `sample_clk` pulse at STOP `tick`=5, in the same cycle.
- `rx_start` and `rx_done` are never high in the same cycle.
- The earliest next `rx_start` is 1 cycle after `rx_done`.
- A `sample_clk` pulse in the cycle the state changes counts toward the new state only if the change happened on an earlier cycle. Transitions occur on the pulse itself, so no pulse is double-counted.

## Test plan
- 0x55, 8N1, clean line → one `data_valid`; `data`=0x55, `frame_err`=0, `parity_err`=0; exactly one `rx_start` and one `rx_done`.
- 0xA3 with `PARITY_EN`=1, even parity, parity bit driven inverted → `data`=0xA3, `parity_err`=1, `frame_err`=0.
- `rx` low for only 2 sample periods, then high → `rx_done` pulse at START `tick`=5, no `data_valid`, state back to IDLE; a following valid 0x3C frame is received correctly.
- 0xF0 with stop bit driven 0 → `data`=0xF0, `frame_err`=1.
- Back-to-back 0x00 then 0xFF with no idle gap; bit 2 of the second frame has a single inverted sample at `tick`=4 → two `data_valid` pulses, `data` 0x00 then 0xFF, no errors.
- `rst` asserted for 1 cycle in the middle of DATA → all outputs 0, no `rx_done`; the next frame 0x81 is received correctly.
